// File: rtl/div_pkg.sv
// div_pkg: shared opcode codes, FSM state encoding and helpers for the
// iterative RV32M divider.
//   WORD_WIDTH            default operand width
//   DIV_OP_*              opcode codes driven on div_opcode
//   div_state_e           divider FSM states
//   div_op_is_rem()       true when the opcode returns the remainder
//   div_op_is_signed()    true for the signed opcodes (DIV, REM)
package div_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [2:0] DIV_OP_NOP  = 3'd0;
  localparam logic [2:0] DIV_OP_DIV  = 3'd1;
  localparam logic [2:0] DIV_OP_DIVU = 3'd2;
  localparam logic [2:0] DIV_OP_REM  = 3'd3;
  localparam logic [2:0] DIV_OP_REMU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic div_op_is_rem(input logic [2:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

  function automatic logic div_op_is_signed(input logic [2:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rem_i    partial remainder (always < divisor_i)
//   quo_i    dividend bits not yet consumed / quotient bits produced so far
//   divisor_i unsigned divisor magnitude
//   rem_o    next partial remainder
//   quo_o    next quotient register (new bit in the LSB)
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;
  logic                fits;

  // rem_i < divisor_i, so the shifted remainder is below 2*divisor and the
  // difference lies in (-2^W, 2^W): its MSB at W+1 bits is a clean sign bit.
  assign shifted = {rem_i, quo_i[DATA_WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_i};
  assign fits    = ~trial[DATA_WIDTH];

  assign rem_o = fits ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  assign quo_o = {quo_i[DATA_WIDTH-2:0], fits};

endmodule

// File: rtl/div.sv
// div: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Normal requests take 33 cycles from acceptance to the result pulse;
// divide-by-zero and signed overflow answer in one cycle.
//   clk, rst          clock, synchronous active-high reset
//   div_start         request strobe, honoured only in IDLE with a non-NOP op
//   div_opcode        DIV_OP_* code
//   div_data1/2       dividend / divisor
//   div_kill          (only with DIV_KILL_EN) abort the request in flight
//   div_busy          request in progress
//   div_result_valid  one-cycle pulse with a new div_result
//   div_result        quotient or remainder, held until the next result
// Optional feature macro: DIV_KILL_EN.
module div
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef DIV_KILL_EN
  input  logic                  div_kill,
`endif
  input  logic                  div_start,
  input  logic [2:0]            div_opcode,
  input  logic [DATA_WIDTH-1:0] div_data1,
  input  logic [DATA_WIDTH-1:0] div_data2,
  output logic                  div_busy,
  output logic                  div_result_valid,
  output logic [DATA_WIDTH-1:0] div_result
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  signed_q, signed_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  vld_q, vld_d;
`ifdef DIV_KILL_EN
  // Previous result, restored if the pulse is killed in DONE so the
  // visible result does not change for a flushed request.
  logic [DATA_WIDTH-1:0] res_prev_q, res_prev_d;
`endif

  logic                  kill;
  logic [DATA_WIDTH-1:0] step_rem, step_quo;

  // Acceptance-time decode
  logic                  acc_signed, sign1, sign2;
  logic [DATA_WIDTH-1:0] abs1, abs2;
  logic                  by_zero, ovf;
  // Final correction
  logic [DATA_WIDTH-1:0] fin_quo, fin_rem;

`ifdef DIV_KILL_EN
  assign kill = div_kill;
`else
  assign kill = 1'b0;
`endif

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    acc_signed = div_op_is_signed(div_opcode);
    sign1      = acc_signed & div_data1[DATA_WIDTH-1];
    sign2      = acc_signed & div_data2[DATA_WIDTH-1];
    abs1       = sign1 ? (~div_data1 + 1'b1) : div_data1;
    abs2       = sign2 ? (~div_data2 + 1'b1) : div_data2;
    by_zero    = (div_data2 == '0);
    ovf        = acc_signed && (div_data1 == MIN_NEG) && (div_data2 == '1);
    fin_quo    = (q_neg_q && signed_q) ? (~step_quo + 1'b1) : step_quo;
    fin_rem    = (r_neg_q && signed_q) ? (~step_rem + 1'b1) : step_rem;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    vld_d    = 1'b0;
`ifdef DIV_KILL_EN
    res_prev_d = res_prev_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (div_start && (div_opcode != DIV_OP_NOP)) begin
          op_d     = div_opcode;
          signed_d = acc_signed;
          q_neg_d  = sign1 ^ sign2;
          r_neg_d  = sign1;
          rem_d    = '0;
          quo_d    = abs1;
          dvsr_d   = abs2;
          cnt_d    = '0;
          if (by_zero || ovf) begin
            // Corner cases skip the iteration and publish next cycle.
            state_d = ST_DONE;
            vld_d   = 1'b1;
`ifdef DIV_KILL_EN
            res_prev_d = res_q;
`endif
            if (by_zero)
              res_d = div_op_is_rem(div_opcode) ? div_data1 : '1;
            else
              res_d = div_op_is_rem(div_opcode) ? '0 : MIN_NEG;
          end else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            // Last step: sign-correct and register so the pulse lines up
            // with the DONE cycle.
            state_d = ST_DONE;
            vld_d   = 1'b1;
`ifdef DIV_KILL_EN
            res_prev_d = res_q;
`endif
            res_d = div_op_is_rem(op_q) ? fin_rem : fin_quo;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef DIV_KILL_EN
        if (kill) res_d = res_prev_q;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= DIV_OP_NOP;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      vld_q    <= 1'b0;
`ifdef DIV_KILL_EN
      res_prev_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      vld_q    <= vld_d;
`ifdef DIV_KILL_EN
      res_prev_q <= res_prev_d;
`endif
    end
  end

  assign div_busy         = (state_q != ST_IDLE);
  assign div_result_valid = vld_q & ~kill;
`ifdef DIV_KILL_EN
  assign div_result       = (vld_q && kill) ? res_prev_q : res_q;
`else
  assign div_result       = res_q;
`endif

endmodule

// File: tb/tb_div.sv
// tb_div: self-checking bench for div. Directed table, hand-written
// corner sequences (ignored restart, reset abort, optional kill) and a
// randomized regression against an arithmetic reference model.
module tb_div;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic [2:0]  div_opcode;
  logic [31:0] div_data1, div_data2;
  logic        div_busy, div_result_valid;
  logic [31:0] div_result;
`ifdef DIV_KILL_EN
  logic        div_kill = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef DIV_KILL_EN
    .div_kill         (div_kill),
`endif
    .div_start        (div_start),
    .div_opcode       (div_opcode),
    .div_data1        (div_data1),
    .div_data2        (div_data2),
    .div_busy         (div_busy),
    .div_result_valid (div_result_valid),
    .div_result       (div_result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } tv_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V division semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) return (op == DIV_OP_DIV || op == DIV_OP_DIVU) ? 32'hFFFF_FFFF : a;
    case (op)
      DIV_OP_DIV:  return 32'(sa / sb);
      DIV_OP_REM:  return 32'(sa % sb);
      DIV_OP_DIVU: return a / b;
      default:     return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    bit sgn;
    sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one request; report result, cycles from acceptance to the pulse
  // (0 = timeout) and whether busy stayed high the whole time.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    div_opcode = op; div_data1 = a; div_data2 = b; div_start = 1'b1;
    tick;
    div_start = 1'b0; div_opcode = DIV_OP_NOP;
    lat = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (!div_busy) busy_ok = 1'b0;
      if (div_result_valid) begin
        lat = k;
        break;
      end
      tick;
    end
    res = div_result;
  endtask

  task automatic do_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int elat,
                        input bit full);
    logic [31:0] res;
    int lat;
    bit busy_ok;
    run_op(op, a, b, res, lat, busy_ok);
    chk({name, " result"}, res, exp);
    chk({name, " latency"}, lat, elat);
    tick;
    if (full) begin
      chk({name, " busy during op"}, {31'd0, busy_ok}, 32'd1);
      chk({name, " pulse one cycle"}, {31'd0, div_result_valid}, 32'd0);
      chk({name, " idle after done"}, {31'd0, div_busy}, 32'd0);
      chk({name, " result held"}, div_result, exp);
    end
  endtask

  initial begin
    tv_t tv[12];
    logic [31:0] res, a, b;
    int lat, seen;
    bit busy_ok;
    logic [2:0] ops[4];

    tv[0]  = '{DIV_OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    tv[1]  = '{DIV_OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    tv[2]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33};
    tv[3]  = '{DIV_OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33};
    tv[4]  = '{DIV_OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    tv[5]  = '{DIV_OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    tv[6]  = '{DIV_OP_REM,  32'd5,         32'd0,         32'd5,         1};
    tv[7]  = '{DIV_OP_REMU, 32'd5,         32'd0,         32'd5,         1};
    tv[8]  = '{DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tv[9]  = '{DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    tv[10] = '{DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    tv[11] = '{DIV_OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33};

    ops[0] = DIV_OP_DIV; ops[1] = DIV_OP_DIVU; ops[2] = DIV_OP_REM; ops[3] = DIV_OP_REMU;

    rst = 1'b1; div_start = 1'b0; div_opcode = DIV_OP_NOP; div_data1 = '0; div_data2 = '0;
    tick; tick;
    rst = 1'b0;
    chk("reset busy", {31'd0, div_busy}, 32'd0);
    chk("reset valid", {31'd0, div_result_valid}, 32'd0);
    chk("reset result", div_result, 32'd0);

    // NOP start is ignored
    div_start = 1'b1; div_opcode = DIV_OP_NOP; div_data1 = 32'd9; div_data2 = 32'd3;
    tick;
    div_start = 1'b0;
    chk("nop ignored", {31'd0, div_busy}, 32'd0);

    for (int i = 0; i < 12; i++)
      do_vec($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].exp, tv[i].lat, 1'b1);

    // Second start during CALC must be ignored and not queued.
    div_opcode = DIV_OP_DIV; div_data1 = 32'hFFFF_FFF9; div_data2 = 32'd2; div_start = 1'b1;
    tick;
    div_start = 1'b0;
    repeat (4) tick;
    div_opcode = DIV_OP_DIVU; div_data1 = 32'd100; div_data2 = 32'd3; div_start = 1'b1;
    tick;
    div_start = 1'b0; div_opcode = DIV_OP_NOP;
    lat = 0;
    for (int k = 6; k <= 60; k++) begin
      if (div_result_valid) begin lat = k; break; end
      tick;
    end
    chk("restart ignored latency", lat, 33);
    chk("restart ignored result", div_result, 32'hFFFF_FFFD);
    seen = 0;
    for (int k = 0; k < 45; k++) begin
      tick;
      if (div_result_valid) seen++;
    end
    chk("restart not queued", seen, 0);

    // Reset in the middle of a division aborts it silently.
    div_opcode = DIV_OP_DIVU; div_data1 = 32'd1000; div_data2 = 32'd7; div_start = 1'b1;
    tick;
    div_start = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort busy", {31'd0, div_busy}, 32'd0);
    chk("abort valid", {31'd0, div_result_valid}, 32'd0);
    chk("abort result", div_result, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (div_result_valid) seen++;
      tick;
    end
    chk("abort no pulse", seen, 0);

`ifdef DIV_KILL_EN
    for (int t = 0; t < 8; t++) begin
      logic [31:0] prev;
      prev = div_result;
      div_opcode = DIV_OP_DIV; div_data1 = $urandom; div_data2 = $urandom | 32'd1;
      div_start = 1'b1;
      tick;
      div_start = 1'b0;
      repeat ($urandom_range(0, 30)) tick;
      div_kill = 1'b1;
      // start in the same cycle as kill loses
      div_start = 1'b1;
      #1;
      chk("kill valid low", {31'd0, div_result_valid}, 32'd0);
      tick;
      div_kill = 1'b0; div_start = 1'b0;
      chk("kill idle", {31'd0, div_busy}, 32'd0);
      chk("kill result kept", div_result, prev);
      a = $urandom; b = $urandom_range(1, 1000);
      do_vec("after kill", DIV_OP_DIVU, a, b, a / b, 33, 1'b0);
    end
`endif

    // Randomized regression against the arithmetic model.
    for (int o = 0; o < 4; o++) begin
      for (int n = 0; n < 120; n++) begin
        case ($urandom_range(0, 9))
          0: begin a = $urandom; b = 32'd0; end
          1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
          3: begin a = $urandom; b = -($urandom_range(1, 20)); end
          default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
        endcase
        run_op(ops[o], a, b, res, lat, busy_ok);
        total++;
        if (res !== ref_div(ops[o], a, b) || lat != ref_lat(ops[o], a, b) || !busy_ok) begin
          bad++;
          $display("FAIL rand op%0d %h/%h: got %h lat %0d expected %h lat %0d",
                   ops[o], a, b, res, lat, ref_div(ops[o], a, b), ref_lat(ops[o], a, b));
        end
        tick;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
